// File: rtl/seq_signed_mac_pkg.sv
// Shared types and helpers for the sequential signed/unsigned multiply-accumulate block.
package seq_signed_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must reach B_WIDTH+1: B_WIDTH+1 partial-product steps plus one accumulate cycle.
    function automatic int unsigned cnt_width(input int unsigned b_width);
        return $clog2(b_width + 2);
    endfunction

endpackage

// File: rtl/seq_signed_mac_step_dp.sv
// One shift-and-add step: folds the shifted, extended multiplicand into the partial product.
module seq_signed_mac_step_dp
    import seq_signed_mac_pkg::*;
#(
    parameter int unsigned A_WIDTH = 16,
    parameter int unsigned B_WIDTH = 16,
    parameter int unsigned CNT_W   = cnt_width(B_WIDTH)
) (
    input  logic [A_WIDTH+B_WIDTH-1:0] partial,
    input  logic [A_WIDTH:0]           a_ext,
    input  logic                       b_bit,
    input  logic [CNT_W-1:0]           idx,
    output logic [A_WIDTH+B_WIDTH-1:0] partial_next_c
);

    localparam int unsigned PROD_W = A_WIDTH + B_WIDTH;

    logic [PROD_W-1:0] addend;

    // Arithmetic is mod 2^PROD_W; the exact product fits, so truncated intermediates are harmless.
    always_comb begin
        addend         = {{(B_WIDTH - 1){a_ext[A_WIDTH]}}, a_ext} << idx;
        partial_next_c = partial;
        if (b_bit) begin
            if (32'(idx) == B_WIDTH) begin
                partial_next_c = partial - addend;
            end else begin
                partial_next_c = partial + addend;
            end
        end
    end

endmodule

// File: rtl/seq_signed_mac.sv
// Iterative multiply-accumulate: one partial product per clock, valid/ready on both sides, sticky overflow.
module seq_signed_mac
    import seq_signed_mac_pkg::*;
#(
    parameter int unsigned A_WIDTH    = 16,
    parameter int unsigned B_WIDTH    = 16,
    parameter int unsigned GUARD_BITS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [A_WIDTH-1:0]                    a,
    input  logic [B_WIDTH-1:0]                    b,
    input  logic                                  a_signed,
    input  logic                                  b_signed,
    input  logic                                  acc_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [A_WIDTH+B_WIDTH+GUARD_BITS-1:0] p,
    output logic                                  ovf
);

    localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH + GUARD_BITS;
    localparam int unsigned PROD_W  = A_WIDTH + B_WIDTH;
    localparam int unsigned CNT_W   = cnt_width(B_WIDTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [A_WIDTH:0]     a_ext_q, a_ext_d;
    logic [B_WIDTH:0]     b_ext_q, b_ext_d;
    logic                 signed_q, signed_d;
    logic                 acc_en_q, acc_en_d;
    logic [PROD_W-1:0]    partial_q, partial_d;
    logic [P_WIDTH-1:0]   acc_q, acc_d;
    logic [P_WIDTH-1:0]   p_q, p_d;
    logic                 ovf_q, ovf_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic                 b_bit_c;
    logic [PROD_W-1:0]    step_c;
    logic [P_WIDTH-1:0]   acc_base_c;
    logic [P_WIDTH-1:0]   prod_ext_c;
    logic [P_WIDTH:0]     sum_c;
    logic                 sovf_c;

    assign b_bit_c = b_ext_q[cnt_q];

    seq_signed_mac_step_dp #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .CNT_W   (CNT_W)
    ) u_step (
        .partial        (partial_q),
        .a_ext          (a_ext_q),
        .b_bit          (b_bit_c),
        .idx            (cnt_q),
        .partial_next_c (step_c)
    );

    // Final accumulate, done one cycle after the last step to keep it off the step adder path.
    always_comb begin
        acc_base_c = acc_en_q ? acc_q : '0;
        if (signed_q) begin
            prod_ext_c = P_WIDTH'($signed(partial_q));
        end else begin
            prod_ext_c = P_WIDTH'(partial_q);
        end
        sum_c  = {1'b0, acc_base_c} + {1'b0, prod_ext_c};
        sovf_c = (acc_base_c[P_WIDTH-1] == prod_ext_c[P_WIDTH-1]) &&
                 (sum_c[P_WIDTH-1] != acc_base_c[P_WIDTH-1]);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_ext_d     = a_ext_q;
        b_ext_d     = b_ext_q;
        signed_d    = signed_q;
        acc_en_d    = acc_en_q;
        partial_d   = partial_q;
        acc_d       = acc_q;
        p_d         = p_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_ext_d   = {a_signed & a[A_WIDTH-1], a};
                    b_ext_d   = {b_signed & b[B_WIDTH-1], b};
                    signed_d  = a_signed | b_signed;
                    acc_en_d  = acc_en;
                    partial_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(B_WIDTH + 1)) begin
                    p_d         = sum_c[P_WIDTH-1:0];
                    acc_d       = sum_c[P_WIDTH-1:0];
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                    if (!acc_en_q) begin
                        ovf_d = 1'b0;
                    end else if (signed_q) begin
                        ovf_d = ovf_q | sovf_c;
                    end else begin
                        ovf_d = ovf_q | sum_c[P_WIDTH];
                    end
                end else begin
                    partial_d = step_c;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_ext_q     <= '0;
            b_ext_q     <= '0;
            signed_q    <= 1'b0;
            acc_en_q    <= 1'b0;
            partial_q   <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_ext_q     <= a_ext_d;
            b_ext_q     <= b_ext_d;
            signed_q    <= signed_d;
            acc_en_q    <= acc_en_d;
            partial_q   <= partial_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_signed_mac.sv
// Bench for seq_signed_mac: two 8x8 instances (4 and 0 guard bits) against a transaction-level reference model.
module tb_seq_signed_mac;

    localparam int W   = 8;
    localparam int PWG = 20;
    localparam int PWZ = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, out_ready;
    logic [W-1:0]   a, b;
    logic           a_signed, b_signed, acc_en;
    logic           in_ready_g, in_ready_z, out_valid_g, out_valid_z, ovf_g, ovf_z;
    logic [PWG-1:0] p_g;
    logic [PWZ-1:0] p_z;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_signed_mac #(.A_WIDTH(W), .B_WIDTH(W), .GUARD_BITS(4)) dut_g (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_g),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .acc_en(acc_en),
        .out_valid(out_valid_g), .out_ready(out_ready), .p(p_g), .ovf(ovf_g)
    );

    seq_signed_mac #(.A_WIDTH(W), .B_WIDTH(W), .GUARD_BITS(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .acc_en(acc_en),
        .out_valid(out_valid_z), .out_ready(out_ready), .p(p_z), .ovf(ovf_z)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sx(input logic [W-1:0] v, input logic s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    // Exact (unwrapped) value of base + a*b, with acc read signed in signed mode.
    function automatic longint exact(input int pw, input longint acc, input logic [W-1:0] av,
                                     input logic [W-1:0] bv, input logic as_, input logic bs_,
                                     input logic ae);
        longint base;
        base = 0;
        if (ae) begin
            if ((as_ | bs_) && acc >= (longint'(1) << (pw - 1))) base = acc - (longint'(1) << pw);
            else base = acc;
        end
        return base + sx(av, as_) * sx(bv, bs_);
    endfunction

    function automatic longint model_p(input int pw, input longint acc, input logic [W-1:0] av,
                                       input logic [W-1:0] bv, input logic as_, input logic bs_,
                                       input logic ae);
        return exact(pw, acc, av, bv, as_, bs_, ae) & ((longint'(1) << pw) - 1);
    endfunction

    function automatic logic model_ovf(input int pw, input longint acc, input logic old,
                                       input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic as_, input logic bs_, input logic ae);
        longint e, half;
        e    = exact(pw, acc, av, bv, as_, bs_, ae);
        half = longint'(1) << (pw - 1);
        if (!ae) return 1'b0;
        if (as_ | bs_) return old | (e < -half || e >= half);
        return old | (e > ((longint'(1) << pw) - 1));
    endfunction

    logic         m_busy, m_valid;
    int           m_cnt;
    logic [W-1:0] l_a, l_b;
    logic         l_as, l_bs, l_ae;
    longint       m_acc_g, m_acc_z, m_p_g, m_p_z;
    logic         m_ovf_g, m_ovf_z;

    // Result appears W+2 cycles after acceptance; no overlap until the result is taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
            m_acc_g <= 0; m_acc_z <= 0; m_p_g <= 0; m_p_z <= 0;
            m_ovf_g <= 1'b0; m_ovf_z <= 1'b0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
            end
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1; m_cnt <= 0;
                l_a <= a; l_b <= b; l_as <= a_signed; l_bs <= b_signed; l_ae <= acc_en;
            end
        end else if (m_cnt == W + 1) begin
            m_p_g   <= model_p(PWG, m_acc_g, l_a, l_b, l_as, l_bs, l_ae);
            m_acc_g <= model_p(PWG, m_acc_g, l_a, l_b, l_as, l_bs, l_ae);
            m_ovf_g <= model_ovf(PWG, m_acc_g, m_ovf_g, l_a, l_b, l_as, l_bs, l_ae);
            m_p_z   <= model_p(PWZ, m_acc_z, l_a, l_b, l_as, l_bs, l_ae);
            m_acc_z <= model_p(PWZ, m_acc_z, l_a, l_b, l_as, l_bs, l_ae);
            m_ovf_z <= model_ovf(PWZ, m_acc_z, m_ovf_z, l_a, l_b, l_as, l_bs, l_ae);
            m_valid <= 1'b1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_g", 64'(in_ready_g), 64'(!m_busy));
            chk("in_ready_z", 64'(in_ready_z), 64'(!m_busy));
            chk("out_valid_g", 64'(out_valid_g), 64'(m_valid));
            chk("out_valid_z", 64'(out_valid_z), 64'(m_valid));
            if (m_valid) begin
                chk("p_g", 64'(p_g), 64'(m_p_g));
                chk("p_z", 64'(p_z), 64'(m_p_z));
                chk("ovf_g", 64'(ovf_g), 64'(m_ovf_g));
                chk("ovf_z", 64'(ovf_z), 64'(m_ovf_z));
            end
        end
    end

    // ---------------- driver ----------------
    logic [63:0] r_pg, r_pz;
    logic        r_og, r_oz;
    int          r_lat;

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tas,
                          input logic tbs, input logic tae, input int hold);
        int k;
        @(negedge clk);
        a = ta; b = tb_; a_signed = tas; b_signed = tbs; acc_en = tae; in_valid = 1'b1;
        out_ready = 1'b0;
        k = 0;
        while (!in_ready_g && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed low for %0d cycles", k);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        r_lat = 0;
        do begin
            @(posedge clk);
            r_lat++;
            @(negedge clk);
            // noise that a busy block must ignore
            in_valid  = 1'($urandom);
            a         = W'($urandom);
            b         = W'($urandom);
            acc_en    = 1'($urandom);
            out_ready = out_valid_g ? 1'b0 : 1'($urandom);
        end while (!out_valid_g && r_lat < 50);
        if (r_lat >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL result_timeout: out_valid stayed low for %0d cycles", r_lat);
        end
        r_pg = 64'(p_g); r_pz = 64'(p_z); r_og = ovf_g; r_oz = ovf_z;
        repeat (hold) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; acc_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready_g), 64'd1);
        chk("rst_out_valid", 64'(out_valid_z), 64'd0);
        chk("rst_p", 64'(p_g), 64'd0);
        chk("rst_ovf", 64'(ovf_z), 64'd0);
        rst_n = 1'b1;

        // -128 * -128 signed, latency
        run_op(8'h80, 8'h80, 1, 1, 0, 0);
        chk("t1_p_g", r_pg, 64'd16384);
        chk("t1_p_z", r_pz, 64'd16384);
        chk("t1_ovf", 64'(r_og), 64'd0);
        chk("t1_latency", 64'(r_lat), 64'd10);

        // unsigned zero-extension, mixed-mode sign-extension
        run_op(8'hFF, 8'hFF, 0, 0, 0, 1);
        chk("t2_u_p_g", r_pg, 64'd65025);
        chk("t2_u_p_z", r_pz, 64'd65025);
        run_op(8'hFF, 8'hFF, 1, 0, 0, 0);
        chk("t2_s_p_g", r_pg, 64'h0_FFF01);
        chk("t2_s_p_z", r_pz, 64'h0_FF01);

        // running accumulation
        run_op(8'd3, 8'd4, 1, 1, 0, 0);
        chk("t3_p0", r_pg, 64'd12);
        run_op(8'hFB, 8'd6, 1, 1, 1, 0);
        chk("t3_p1_g", r_pg, 64'h0_FFFEE);
        chk("t3_p1_z", r_pz, 64'h0_FFEE);
        run_op(8'd7, 8'd7, 1, 1, 1, 0);
        chk("t3_p2", r_pz, 64'd31);
        chk("t3_ovf", 64'(r_oz), 64'd0);

        // backpressure with in_valid pressure during DONE
        run_op(8'd1, 8'd2, 0, 0, 0, 5);
        chk("t4_p", r_pg, 64'd2);
        run_op(8'd3, 8'd3, 0, 0, 0, 0);
        chk("t4_next", r_pz, 64'd9);

        // overflow with no guard bits
        run_op(8'd127, 8'd127, 1, 1, 0, 0);
        run_op(8'd127, 8'd127, 1, 1, 1, 0);
        chk("t5_ovf_2", 64'(r_oz), 64'd0);
        run_op(8'd127, 8'd127, 1, 1, 1, 0);
        chk("t5_ovf_3", 64'(r_oz), 64'd1);
        chk("t5_p_z", r_pz, 64'hBD03);
        chk("t5_p_g", r_pg, 64'd48387);
        chk("t5_ovf_g", 64'(r_og), 64'd0);
        run_op(8'd1, 8'd1, 1, 1, 1, 0);
        chk("t5_sticky", 64'(r_oz), 64'd1);
        run_op(8'd1, 8'd1, 1, 1, 0, 0);
        chk("t5_clear", 64'(r_oz), 64'd0);
        repeat (3) run_op(8'd127, 8'd127, 1, 1, 1, 0);
        chk("t5_reovf", 64'(r_oz), 64'd1);

        // reset in the middle of RUN
        @(negedge clk);
        a = 8'd9; b = 8'd9; a_signed = 1'b1; b_signed = 1'b1; acc_en = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 64'(out_valid_g), 64'd0);
        chk("t6_p", 64'(p_z), 64'd0);
        chk("t6_ovf", 64'(ovf_z), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", 64'(in_ready_z), 64'd1);
        run_op(8'd2, 8'd3, 1, 1, 1, 0);
        chk("t6_p_after", r_pg, 64'd6);
        chk("t6_p_after_z", r_pz, 64'd6);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(3) != 0), $urandom_range(3));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
